sumador_autotest: RTL and testbench



---
 rtl/sumador_autotest.sv | 115 +++++++++++
 tb/tb_sumador_autotest.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sumador_autotest.sv
// Built-in self-test sequencer for the 1-bit full adder: sweeps all 8 vectors, settles, samples, scores.
// Optional SUMADOR_AUTOTEST_LOOP_EN: holding start at the end of a sweep wraps into a new sweep (soak mode).
module sumador_autotest #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       fa_a,
   output logic       fa_b,
   output logic       fa_cin,
   input  logic       fa_s,
   input  logic       fa_cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       fail_valid,
   output logic [2:0] first_fail
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   state_t     state, state_n;
   logic [2:0] v, v_n;
   logic [3:0] cnt, cnt_n;
   logic [3:0] err_n;
   logic       fv_n;
   logic [2:0] ff_n;
   logic       exp_s, exp_c, mismatch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         v          <= 3'd0;
         cnt        <= 4'd0;
         err_count  <= 4'd0;
         fail_valid <= 1'b0;
         first_fail <= 3'd0;
      end else begin
         state      <= state_n;
         v          <= v_n;
         cnt        <= cnt_n;
         err_count  <= err_n;
         fail_valid <= fv_n;
         first_fail <= ff_n;
      end
   end

   assign exp_s    = v[2] ^ v[1] ^ v[0];
   assign exp_c    = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
   // Sum, carry or both wrong on one vector is a single error.
   assign mismatch = (fa_s != exp_s) || (fa_cout != exp_c);

   always_comb begin
      state_n = state;
      v_n     = v;
      cnt_n   = cnt;
      err_n   = err_count;
      fv_n    = fail_valid;
      ff_n    = first_fail;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = DRIVE;
               v_n     = 3'd0;
               cnt_n   = 4'd1;
               err_n   = 4'd0;
               fv_n    = 1'b0;
               ff_n    = 3'd0;
            end
         end
         DRIVE: begin
            if (cnt == SETTLE_C) state_n = CHECK;
            else                 cnt_n   = cnt + 4'd1;
         end
         CHECK: begin
            if (mismatch) begin
               if (err_count != 4'd15) err_n = err_count + 4'd1;
               if (!fail_valid) begin
                  fv_n = 1'b1;
                  ff_n = v;
               end
            end
            cnt_n = 4'd1;
            if (v == 3'd7) begin
`ifdef SUMADOR_AUTOTEST_LOOP_EN
               // Wrap keeps the score so a soak run accumulates errors.
               if (start) begin
                  state_n = DRIVE;
                  v_n     = 3'd0;
               end else begin
                  state_n = DONE;
               end
`else
               state_n = DONE;
`endif
            end else begin
               v_n     = v + 3'd1;
               state_n = DRIVE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // DONE keeps vector 7 on the operands; IDLE forces them quiet.
   assign {fa_a, fa_b, fa_cin} = (state == IDLE) ? 3'd0 : v;
   assign busy = (state == DRIVE) || (state == CHECK);
   assign done = (state == DONE);
   assign pass = done && (err_count == 4'd0);

endmodule

// File: tb/tb_sumador_autotest.sv
// Self-checking bench: fault-injectable behavioural adder, randomized faults and start pulses, scored by a vector-level model.
module tb_sumador_autotest;

   localparam int SETTLE = 2;
   localparam int VLEN   = SETTLE + 1;
   localparam int SWEEP  = 8 * VLEN;

   logic       clk = 1'b0;
   logic       rst, start;
   logic       fa_a, fa_b, fa_cin, fa_s, fa_cout;
   logic       busy, done, pass, fail_valid;
   logic [3:0] err_count;
   logic [2:0] first_fail;
   logic [7:0] flip_s, flip_c;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   sumador_autotest #(.SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
      .fa_s(fa_s), .fa_cout(fa_cout),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_valid(fail_valid), .first_fail(first_fail)
   );

   // Adder under test: arithmetic truth with per-vector fault injection.
   always_comb begin
      int tot;
      logic [2:0] vec;
      vec     = {fa_a, fa_b, fa_cin};
      tot     = int'(fa_a) + int'(fa_b) + int'(fa_cin);
      fa_s    = ((tot % 2) == 1) ^ flip_s[vec];
      fa_cout = (tot >= 2) ^ flip_c[vec];
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Score of vectors 0..n-1: number wrong, lowest wrong index, any wrong.
   task automatic model(input int n, output int e, output int f, output int fv);
      e = 0; f = 0; fv = 0;
      for (int i = 0; i < n; i++)
         if (flip_s[i] | flip_c[i]) begin
            if (fv == 0) f = i;
            fv = 1;
            e++;
         end
   endtask

   // One sweep from IDLE/DONE; pulse[k] drives start during cycle k.
   task automatic run_sweep(input string name, input logic [31:0] pulse);
      int e, f, fv, vi;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= SWEEP; k++) begin
         vi = (k - 1) / VLEN;
         chk({name, ".busy"}, {7'd0, busy}, 8'd1);
         chk({name, ".done"}, {7'd0, done}, 8'd0);
         chk({name, ".vec"}, {5'd0, fa_a, fa_b, fa_cin}, 8'(vi));
         if ((k - 1) % VLEN == 0) begin
            model(vi, e, f, fv);
            chk({name, ".err_part"}, {4'd0, err_count}, 8'(e));
            chk({name, ".fv_part"}, {7'd0, fail_valid}, 8'(fv));
         end
         start = pulse[k];
         step();
      end
      start = 1'b0;
      model(8, e, f, fv);
      chk({name, ".end_busy"}, {7'd0, busy}, 8'd0);
      chk({name, ".end_done"}, {7'd0, done}, 8'd1);
      chk({name, ".end_pass"}, {7'd0, pass}, 8'(e == 0));
      chk({name, ".end_err"}, {4'd0, err_count}, 8'(e));
      chk({name, ".end_fv"}, {7'd0, fail_valid}, 8'(fv));
      chk({name, ".end_first"}, {5'd0, first_fail}, 8'(f));
      chk({name, ".end_vec"}, {5'd0, fa_a, fa_b, fa_cin}, 8'd7);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, ".busy"}, {7'd0, busy}, 8'd0);
      chk({name, ".done"}, {7'd0, done}, 8'd0);
      chk({name, ".pass"}, {7'd0, pass}, 8'd0);
      chk({name, ".err"}, {4'd0, err_count}, 8'd0);
      chk({name, ".fv"}, {7'd0, fail_valid}, 8'd0);
      chk({name, ".first"}, {5'd0, first_fail}, 8'd0);
      chk({name, ".vec"}, {5'd0, fa_a, fa_b, fa_cin}, 8'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flip_s = 8'd0; flip_c = 8'd0;
      step(); step();
      rst = 1'b0;
      chk_quiet("reset");
      step();
      chk_quiet("idle_hold");

      run_sweep("good", 32'd0);

      for (int i = 0; i < 8; i++) flip_c[i] = ($countones(i[2:0]) >= 2);
      run_sweep("cout_stuck0", 32'd0);
      chk("cout_stuck0.count", {4'd0, err_count}, 8'd4);
      chk("cout_stuck0.first", {5'd0, first_fail}, 8'd3);

      flip_s = 8'hFF; flip_c = 8'h00;
      run_sweep("s_inv_pulses", (32'd1 << 5) | (32'd1 << 10));
      chk("s_inv.count", {4'd0, err_count}, 8'd8);

      for (int r = 0; r < 5; r++) begin
         flip_s = 8'($urandom);
         flip_c = 8'($urandom) & 8'($urandom);
         run_sweep("random", $urandom & 32'h00FF_FFFE);
      end

      // Reset mid-sweep with start also asserted.
      flip_s = 8'h00; flip_c = 8'h00;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k < 12; k++) step();
      rst = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; start = 1'b0;
      chk_quiet("rst_mid");
      flip_s = 8'h24;
      run_sweep("after_rst", 32'd0);

`ifdef SUMADOR_AUTOTEST_LOOP_EN
      flip_s = 8'hFF; flip_c = 8'h00;
      start = 1'b1;
      step();
      for (int k = 1; k <= 3 * SWEEP; k++) begin
         chk("loop.busy", {7'd0, busy}, 8'd1);
         chk("loop.done", {7'd0, done}, 8'd0);
         if (k == SWEEP + 1)     chk("loop.err_s1", {4'd0, err_count}, 8'd8);
         if (k == 2 * SWEEP + 1) chk("loop.err_s2", {4'd0, err_count}, 8'd15);
         if (k == 2 * SWEEP + 2) start = 1'b0;
         step();
      end
      chk("loop.end_done", {7'd0, done}, 8'd1);
      chk("loop.end_err", {4'd0, err_count}, 8'd15);
      chk("loop.end_first", {5'd0, first_fail}, 8'd0);
      chk("loop.end_fv", {7'd0, fail_valid}, 8'd1);
`else
      // Start held through the end of a sweep must not wrap.
      flip_s = 8'h00; flip_c = 8'h81;
      start = 1'b1;
      step();
      for (int k = 1; k <= SWEEP; k++) step();
      chk("hold.done", {7'd0, done}, 8'd1);
      chk("hold.busy", {7'd0, busy}, 8'd0);
      chk("hold.err", {4'd0, err_count}, 8'd2);
      start = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
